// File: rtl/frame_buf_arb.sv
// rtl/frame_buf_arb.sv - single-port frame-buffer arbiter with double-buffered frame regions
// Round-robin writer/reader sharing, strobe sequencing and frame swap once both sides finish.
module frame_buf_arb #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 29,
    parameter int FRAME_WORDS = 307200,
    parameter int ACC_CYC     = 2
) (
    input  logic                  pll0_pll_clk_clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  frame_swap,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en_n,
    output logic                  mem_rd_en_n,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam logic [ADDR_WIDTH-1:0] FRAME_BASE = ADDR_WIDTH'(FRAME_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam int                    CW         = $clog2(ACC_CYC + 1);
    localparam logic [CW-1:0]         ACC_LAST   = CW'(ACC_CYC);

    typedef enum logic [1:0] {IDLE, WR, RD, REL} state_t;

    state_t                state;
    logic                  wr_buf, rd_buf;
    logic                  wr_done, rd_done;
    logic                  last_wr;          // 1: last grant was the writer
    logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt;
    logic [CW-1:0]         acc_cnt;

    logic                  wr_elig, rd_elig, grant_wr, grant_rd;
    logic [ADDR_WIDTH-1:0] wr_addr_next, rd_addr_next;

    always_comb begin
        wr_elig      = wr_req && !wr_done;
        rd_elig      = rd_req && !rd_done;
        grant_wr     = wr_elig && (!rd_elig || !last_wr);
        grant_rd     = rd_elig && (!wr_elig || last_wr);
        wr_addr_next = (wr_buf ? FRAME_BASE : '0) + wr_cnt;
        rd_addr_next = (rd_buf ? FRAME_BASE : '0) + rd_cnt;
    end

    always_ff @(posedge pll0_pll_clk_clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_buf      <= 1'b0;
            rd_buf      <= 1'b1;
            wr_done     <= 1'b0;
            rd_done     <= 1'b0;
            last_wr     <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            acc_cnt     <= '0;
            wr_ack      <= 1'b0;
            rd_valid    <= 1'b0;
            frame_swap  <= 1'b0;
            rd_data     <= '0;
            mem_wr_data <= '0;
            mem_wr_addr <= '0;
            mem_rd_addr <= '0;
            mem_wr_en_n <= 1'b1;
            mem_rd_en_n <= 1'b1;
        end else begin
            wr_ack     <= 1'b0;
            rd_valid   <= 1'b0;
            frame_swap <= 1'b0;
            case (state)
                IDLE: begin
                    // A pending swap always wins over new grants
                    if (wr_done && rd_done) begin
                        wr_buf     <= ~wr_buf;
                        rd_buf     <= ~rd_buf;
                        wr_done    <= 1'b0;
                        rd_done    <= 1'b0;
                        frame_swap <= 1'b1;
                    end else if (grant_wr) begin
                        mem_wr_data <= wr_data;
                        mem_wr_addr <= wr_addr_next;
                        mem_wr_en_n <= 1'b0;
                        acc_cnt     <= CW'(1);
                        last_wr     <= 1'b1;
                        state       <= WR;
                    end else if (grant_rd) begin
                        mem_rd_addr <= rd_addr_next;
                        mem_rd_en_n <= 1'b0;
                        acc_cnt     <= CW'(1);
                        last_wr     <= 1'b0;
                        state       <= RD;
                    end
                end
                WR, RD: begin
                    if (acc_cnt == ACC_LAST) begin
                        mem_wr_en_n <= 1'b1;
                        mem_rd_en_n <= 1'b1;
                        wr_ack      <= (state == WR);
                        state       <= REL;
                    end else begin
                        acc_cnt <= acc_cnt + CW'(1);
                    end
                end
                REL: begin
                    if (last_wr) begin
                        if (wr_cnt == LAST_IDX) begin
                            wr_cnt  <= '0;
                            wr_done <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
                        end
                    end else begin
                        rd_data  <= mem_rd_data;
                        rd_valid <= 1'b1;
                        if (rd_cnt == LAST_IDX) begin
                            rd_cnt  <= '0;
                            rd_done <= 1'b1;
                        end else begin
                            rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buf_arb.sv
// tb/tb_frame_buf_arb.sv - directed self-checking bench for frame_buf_arb
// Small frames (4 words) with a behavioural memory model behind the strobes.
module tb_frame_buf_arb;

    localparam int DW = 32;
    localparam int AW = 29;
    localparam int FW = 4;
    localparam int AC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req, rd_req;
    logic [DW-1:0] wr_data;
    logic          wr_ack, rd_valid, frame_swap;
    logic [DW-1:0] rd_data, mem_wr_data, mem_rd_data;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic          mem_wr_en_n, mem_rd_en_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem [0:7];

    always #5 clk = ~clk;

    always @(posedge clk) if (!mem_wr_en_n) mem[mem_wr_addr[2:0]] <= mem_wr_data;
    assign mem_rd_data = mem[mem_rd_addr[2:0]];

    frame_buf_arb #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FRAME_WORDS(FW),
        .ACC_CYC    (AC)
    ) dut (
        .pll0_pll_clk_clk(clk),
        .reset           (reset),
        .wr_req          (wr_req),
        .wr_data         (wr_data),
        .wr_ack          (wr_ack),
        .rd_req          (rd_req),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .frame_swap      (frame_swap),
        .mem_wr_addr     (mem_wr_addr),
        .mem_rd_addr     (mem_rd_addr),
        .mem_wr_data     (mem_wr_data),
        .mem_wr_en_n     (mem_wr_en_n),
        .mem_rd_en_n     (mem_rd_en_n),
        .mem_rd_data     (mem_rd_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int   fall_cnt, last_fall, acks, wf, rf, swaps, wf2, rf2, vals;
        logic pw, pr, ack_seen;

        reset   = 1'b1;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_ack",      wr_ack,      0);
        chk("rst_rd_valid",    rd_valid,    0);
        chk("rst_frame_swap",  frame_swap,  0);
        chk("rst_rd_data",     rd_data,     0);
        chk("rst_mem_wr_data", mem_wr_data, 0);
        chk("rst_mem_wr_addr", mem_wr_addr, 0);
        chk("rst_mem_rd_addr", mem_rd_addr, 0);
        chk("rst_wr_en_n",     mem_wr_en_n, 1);
        chk("rst_rd_en_n",     mem_rd_en_n, 1);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", {mem_wr_en_n, mem_rd_en_n, wr_ack, rd_valid, frame_swap}, 5'b11000);
        end

        // Single write
        wr_data = 32'hA5A5_A5A5;
        wr_req  = 1'b1;
        @(negedge clk);
        wr_req  = 1'b0;
        wr_data = '0;
        chk("w1_en_c1",   mem_wr_en_n, 0);
        chk("w1_addr",    mem_wr_addr, 0);
        chk("w1_data",    mem_wr_data, 32'hA5A5_A5A5);
        chk("w1_ack_c1",  wr_ack,      0);
        @(negedge clk);
        chk("w1_en_c2",   mem_wr_en_n, 0);
        chk("w1_rd_en",   mem_rd_en_n, 1);
        @(negedge clk);
        chk("w1_en_rel",  mem_wr_en_n, 1);
        chk("w1_ack_rel", wr_ack,      1);
        @(negedge clk);
        chk("w1_ack_off", wr_ack,      0);

        // Second write lands at the advanced count
        wr_data = 32'h1234_5678;
        wr_req  = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        chk("w2_en",   mem_wr_en_n, 0);
        chk("w2_addr", mem_wr_addr, 1);
        chk("w2_data", mem_wr_data, 32'h1234_5678);
        repeat (3) @(negedge clk);

        // Reset during the strobe of a third write
        wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        chk("w3_en",   mem_wr_en_n, 0);
        chk("w3_addr", mem_wr_addr, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_en_n", mem_wr_en_n, 1);
        chk("rstmid_ack",  wr_ack,      0);
        ack_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wr_ack || !mem_wr_en_n) ack_seen = 1'b1;
        end
        chk("rstmid_no_ack", ack_seen, 0);
        wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        chk("rstmid_en_next",   mem_wr_en_n, 0);
        chk("rstmid_addr_next", mem_wr_addr, 0);
        repeat (3) @(negedge clk);

        // Both requests held: round robin
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        wr_req = 1'b1;
        rd_req = 1'b1;
        fall_cnt  = 0;
        last_fall = -1;
        pw = 1'b1;
        pr = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (c == 31) begin
                wr_req = 1'b0;
                rd_req = 1'b0;
            end
            chk("rr_no_overlap", {mem_wr_en_n, mem_rd_en_n} == 2'b00, 0);
            if (pw && !mem_wr_en_n) begin
                chk("rr_type_w", fall_cnt % 2, 0);
                chk("rr_waddr",  mem_wr_addr, fall_cnt / 2);
            end
            if (pr && !mem_rd_en_n) begin
                chk("rr_type_r", fall_cnt % 2, 1);
                chk("rr_raddr",  mem_rd_addr, 4 + fall_cnt / 2);
            end
            if ((pw && !mem_wr_en_n) || (pr && !mem_rd_en_n)) begin
                if (fall_cnt == 0) chk("rr_first_at", c, 0);
                else               chk("rr_spacing", c - last_fall, 4);
                last_fall = c;
                fall_cnt++;
            end
            pw = mem_wr_en_n;
            pr = mem_rd_en_n;
        end
        chk("rr_count", fall_cnt, 8);
        @(negedge clk);
        chk("rr_swap", frame_swap, 1);

        // Writer fills a frame alone, then stalls
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        wr_req  = 1'b1;
        wr_data = 32'd1;
        acks = 0;
        wf   = 0;
        pw   = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (wr_ack) acks++;
            wr_data = 32'(acks + 1);
            if (pw && !mem_wr_en_n) begin
                if (wf < 4) chk("fa_waddr", mem_wr_addr, wf);
                wf++;
            end
            pw = mem_wr_en_n;
        end
        chk("fa_wcount", wf,   4);
        chk("fa_acks",   acks, 4);
        wr_req = 1'b0;

        // Reader finishes its frame, swap follows
        rd_req = 1'b1;
        rf     = 0;
        swaps  = 0;
        pr     = 1'b1;
        for (int c = 0; c < 60 && swaps == 0; c++) begin
            @(negedge clk);
            if (pr && !mem_rd_en_n) begin
                if (rf < 4) chk("fb_raddr", mem_rd_addr, 4 + rf);
                rf++;
            end
            pr = mem_rd_en_n;
            if (frame_swap) begin
                swaps++;
                chk("fb_swap_alone", wr_ack || rd_valid, 0);
            end
        end
        chk("fb_swap_seen", swaps, 1);
        chk("fb_rcount",    rf,    4);

        // After the swap: write goes to region 1, read-back of region 0
        wr_req  = 1'b1;
        wr_data = 32'h55;
        wf2  = 0;
        rf2  = 0;
        vals = 0;
        pw   = mem_wr_en_n;
        pr   = mem_rd_en_n;
        for (int c = 0; c < 60 && vals < 4; c++) begin
            @(negedge clk);
            if (frame_swap) swaps++;
            if (pw && !mem_wr_en_n) begin
                if (wf2 == 0) chk("fc_waddr0", mem_wr_addr, 4);
                wf2++;
            end
            if (pr && !mem_rd_en_n) begin
                if (rf2 == 0) chk("fc_raddr0", mem_rd_addr, 0);
                rf2++;
            end
            if (rd_valid) begin
                chk("fc_rdata", rd_data, vals + 1);
                vals++;
            end
            pw = mem_wr_en_n;
            pr = mem_rd_en_n;
        end
        chk("fc_vals",      vals,  4);
        chk("fc_swap_once", swaps, 1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buf_arb.md
# frame_buf_arb

Arbiter and sequencer in front of the single-port frame-buffer memory. Shares that memory between a pixel writer (capture side) and a pixel reader (display side). Generates the memory's active-low strobes with the required hold/release timing and auto-increments per-requester addresses. Double-buffers two frame regions and swaps them only when both sides have finished a frame.

## Interface
Parameters:
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 29, memory address width
- FRAME_WORDS, 307200, words per frame; 2*FRAME_WORDS must be <= 2^ADDR_WIDTH and FRAME_WORDS >= 2
- ACC_CYC, 2, cycles a memory strobe is held asserted (>= 2)

Ports:
- pll0_pll_clk_clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_req  in  1  writer requests one word write
- wr_data  in  DATA_WIDTH  write word; sampled when the request is granted
- wr_ack  out  1  one-cycle pulse, word written
- rd_req  in  1  reader requests one word
- rd_data  out  DATA_WIDTH  read word, valid with rd_valid
- rd_valid  out  1  one-cycle pulse
- frame_swap  out  1  one-cycle pulse on buffer swap
- mem_wr_addr, mem_rd_addr  out  ADDR_WIDTH  memory addresses
- mem_wr_data  out  DATA_WIDTH  memory write data
- mem_wr_en_n, mem_rd_en_n  out  1  active-low strobes
- mem_rd_data  in  DATA_WIDTH  memory read data

## Operation
- All outputs are registered. Reset values:
  - wr_ack, rd_valid, frame_swap = 0
  - rd_data, mem_wr_data, mem_*_addr = 0
  - mem_wr_en_n = mem_rd_en_n = 1
- Reset state: IDLE, wr_buf = 0, rd_buf = 1, wr_cnt = rd_cnt = 0, wr_done = rd_done = 0, last = READ.
- Address = buf*FRAME_WORDS + cnt, computed at ADDR_WIDTH bits with no overflow.
- FSM states: IDLE, WR, RD, REL.
- IDLE, priority order:
  1. If wr_done and rd_done: swap. Toggle wr_buf and rd_buf, clear both done flags, pulse frame_swap, stay in IDLE.
  2. Eligible requests: wr_req with !wr_done; rd_req with !rd_done.
  3. Both eligible: grant the side opposite to `last` (round robin). One eligible: grant it. None: stay in IDLE.
- WR grant:
  - Latch wr_data into mem_wr_data and the address into mem_wr_addr.
  - Drive mem_wr_en_n = 0 for ACC_CYC cycles, then go to REL.
  - Set last = WRITE.
- RD grant: same sequence, using mem_rd_addr and mem_rd_en_n. Set last = READ.
- REL (1 cycle):
  - Both strobes deasserted.
  - For a write: wr_ack = 1; wr_cnt increments, or wraps to 0 and sets wr_done if it was FRAME_WORDS-1.
  - For a read: capture mem_rd_data into rd_data at the end of REL; rd_valid = 1 in the following cycle. rd_cnt is updated the same way as wr_cnt and sets rd_done.
  - Next state: IDLE.
- The two strobes are never low in the same cycle.
- A side whose done flag is set is stalled (no grant) until the swap.
- Requests are level-sensitive. A request held high is re-arbitrated in every IDLE cycle. Dropping a request mid-access does not abort the access.
- Reset asserted mid-access: next cycle, strobes are 1, FSM is in IDLE, and counters, flags and buffer selects return to reset values.

## Timing
- Grant sampled in IDLE at edge k. Strobe is low during cycles k+1 .. k+ACC_CYC. REL is cycle k+ACC_CYC+1.
- wr_ack is high in cycle k+ACC_CYC+1.
- rd_valid and rd_data are presented in cycle k+ACC_CYC+2.
- Back-to-back accesses: one access every ACC_CYC+2 cycles (4 with default parameters).
- A swap costs exactly one IDLE cycle and is taken before any grant.
- frame_swap never coincides with wr_ack or rd_valid.

## Test plan
All scenarios use FRAME_WORDS=4, ACC_CYC=2.
- Reset, no requests: all outputs hold reset values; strobes stay 1 for 20 cycles.
- Single write, wr_req pulsed with wr_data=0xA5A5A5A5:
  - mem_wr_en_n low 2 cycles with mem_wr_addr=0 and that data.
  - wr_ack 3 cycles after grant.
  - wr_cnt advances to 1.
- wr_req and rd_req held high together:
  - Grants alternate W, R, W, R, …; first grant is WR (last = READ at reset).
  - Spacing 4 cycles; strobes never overlap.
  - Write addresses 0, 1, 2, 3; read addresses 4, 5, 6, 7.
- Writer completes 4 words while the reader is idle:
  - wr_done set; 5th wr_req not granted.
  - After the reader's 4 reads: frame_swap pulses once.
  - Next write address 4, next read address 0.
- Read-back after swap, with a memory model: frame written as 1, 2, 3, 4 is returned on rd_data as 1, 2, 3, 4, each with a rd_valid pulse.
- Reset asserted during the WR strobe cycle: mem_wr_en_n = 1 the next cycle; no wr_ack; next write address 0.
